// File: rtl/fix_msg_composer.sv
// Outbound FIX 4.3 session message builder (Logon / Heartbeat / Logout).
// Streams ASCII bytes with valid/ready and fills in BodyLength(9) and CheckSum(10) itself.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for send_i; bad type_i pulses err_o
// S_COUNT | size latched fields, convert BodyLength to decimal digits
// S_HDR   | emit "8=FIX.4.3" SOH "9=" len SOH
// S_BODY  | emit 35/34/49/52/56 (+98/108 for Logon)
// S_TRAIL | emit "10=" ccc SOH
// S_DONE  | pulse done_o and seq_inc_o, back to idle
module fix_msg_composer #(
  parameter int         VALUE_WIDTH    = 64,
  parameter int         TIME_WIDTH     = 168,
  parameter logic [3:0] TYPE_LOGON     = 4'hA,
  parameter logic [3:0] TYPE_HEARTBEAT = 4'h0,
  parameter logic [3:0] TYPE_LOGOUT    = 4'h5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   send_i,
  input  logic [3:0]             type_i,
  input  logic [VALUE_WIDTH-1:0] seq_ascii_i,
  input  logic [VALUE_WIDTH-1:0] sender_id_i,
  input  logic [VALUE_WIDTH-1:0] target_id_i,
  input  logic [TIME_WIDTH-1:0]  send_time_i,
  input  logic [23:0]            hb_int_i,
  output logic                   ready_o,
  output logic [7:0]             data_o,
  output logic                   data_valid_o,
  input  logic                   data_ready_i,
  output logic                   done_o,
  output logic                   seq_inc_o,
  output logic                   err_o
);

  localparam int MAXW0 = (VALUE_WIDTH > TIME_WIDTH) ? VALUE_WIDTH : TIME_WIDTH;
  localparam int MAXW  = (MAXW0 > 80) ? MAXW0 : 80;
  localparam int IW    = $clog2(MAXW);
  localparam logic [7:0] SOH = 8'h01;

  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_HDR, S_BODY, S_TRAIL, S_DONE} state_t;
  state_t state;

  logic [3:0]             type_q;
  logic [VALUE_WIDTH-1:0] seq_q, snd_q, tgt_q;
  logic [TIME_WIDTH-1:0]  time_q;
  logic [23:0]            hb_q;
  logic [7:0]             seq_len, snd_len, tgt_len, time_len, hb_len;
  logic                   cnt_first;
  logic [9:0]             blen_rem;
  logic [3:0]             dig_h, dig_t, dig_o;
  logic [4:0]             seg;
  logic [7:0]             r;
  logic                   emit_end, out_cks;
  logic [7:0]             cks;

  // Significant byte count: position of the highest non-zero byte.
  function automatic logic [7:0] nz_len(input logic [MAXW-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int k = 0; k < MAXW/8; k++)
      if (v[8*k +: 8] != 8'h00) n = 8'(k+1);
    return n;
  endfunction

  function automatic logic [11:0] dec3(input logic [7:0] v);
    logic [7:0] m;
    logic [3:0] h, t;
    h = (v >= 8'd200) ? 4'd2 : (v >= 8'd100) ? 4'd1 : 4'd0;
    m = v - 8'(h) * 8'd100;
    t = '0;
    for (int k = 1; k < 10; k++)
      if (m >= 8'(10*k)) t = 4'(k);
    return {h, t, 4'(m - 8'(t) * 8'd10)};
  endfunction

  logic        is_logon;
  logic [7:0]  msg_char, seq_n, snd_n, tgt_n, time_n, hb_n, ndig;
  logic [9:0]  blen_calc;
  logic [11:0] cks_dig;
  logic [MAXW-1:0] src;
  logic [IW-1:0]   bsel;
  logic [7:0]  cur_byte, nxt_len;
  logic [4:0]  nxt_seg;

  always_comb begin
    is_logon = (type_q == TYPE_LOGON);
    msg_char = is_logon ? "A" : (type_q == TYPE_LOGOUT) ? "5" : "0";
    seq_n    = nz_len(MAXW'(seq_q));
    snd_n    = nz_len(MAXW'(snd_q));
    tgt_n    = nz_len(MAXW'(tgt_q));
    time_n   = nz_len(MAXW'(time_q));
    hb_n     = nz_len(MAXW'(hb_q));
    blen_calc = 10'd5 + 10'd3 + 10'(seq_n) + 10'd4 + 10'(snd_n) + 10'd4 + 10'(time_n)
              + 10'd4 + 10'(tgt_n) + 10'd1 + (is_logon ? 10'd10 + 10'(hb_n) : 10'd0);
    ndig     = (dig_h != 4'd0) ? 8'd3 : (dig_t != 4'd0) ? 8'd2 : 8'd1;
    cks_dig  = dec3(cks);
  end

  // Each segment is a right-aligned byte string; r counts down the bytes left in it.
  always_comb begin
    src = '0;
    case (seg)
      5'd0:  src = MAXW'({"8=FIX.4.3", SOH});
      5'd1:  src = MAXW'("9=");
      5'd2:  src = MAXW'({4'h3, dig_h, 4'h3, dig_t, 4'h3, dig_o});
      5'd4:  src = MAXW'({"35=", msg_char, SOH});
      5'd5:  src = MAXW'("34=");
      5'd6:  src = MAXW'(seq_q);
      5'd7:  src = MAXW'({SOH, "49="});
      5'd8:  src = MAXW'(snd_q);
      5'd9:  src = MAXW'({SOH, "52="});
      5'd10: src = MAXW'(time_q);
      5'd11: src = MAXW'({SOH, "56="});
      5'd12: src = MAXW'(tgt_q);
      5'd14: src = MAXW'({"98=0", SOH, "108="});
      5'd15: src = MAXW'(hb_q);
      5'd17: src = MAXW'("10=");
      5'd18: src = MAXW'({4'h3, cks_dig[11:8], 4'h3, cks_dig[7:4], 4'h3, cks_dig[3:0]});
      default: src = MAXW'(SOH);
    endcase
    bsel     = IW'({r, 3'b000} - 11'd8);
    cur_byte = src[bsel +: 8];

    // Empty fields are jumped over so the stream never bubbles.
    nxt_seg = seg + 5'd1;
    case (seg)
      5'd5:  if (seq_len == 8'd0)  nxt_seg = 5'd7;
      5'd7:  if (snd_len == 8'd0)  nxt_seg = 5'd9;
      5'd9:  if (time_len == 8'd0) nxt_seg = 5'd11;
      5'd11: if (tgt_len == 8'd0)  nxt_seg = 5'd13;
      5'd13: if (!is_logon)        nxt_seg = 5'd17;
      5'd14: if (hb_len == 8'd0)   nxt_seg = 5'd16;
      default: ;
    endcase
    case (nxt_seg)
      5'd1:                    nxt_len = 8'd2;
      5'd2:                    nxt_len = ndig;
      5'd4:                    nxt_len = 8'd5;
      5'd5, 5'd17, 5'd18:      nxt_len = 8'd3;
      5'd6:                    nxt_len = seq_len;
      5'd7, 5'd9, 5'd11:       nxt_len = 8'd4;
      5'd8:                    nxt_len = snd_len;
      5'd10:                   nxt_len = time_len;
      5'd12:                   nxt_len = tgt_len;
      5'd14:                   nxt_len = 8'd9;
      5'd15:                   nxt_len = hb_len;
      default:                 nxt_len = 8'd1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      ready_o      <= 1'b1;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      done_o       <= 1'b0;
      seq_inc_o    <= 1'b0;
      err_o        <= 1'b0;
      cnt_first    <= 1'b0;
      seg          <= '0;
      r            <= '0;
      emit_end     <= 1'b0;
      out_cks      <= 1'b0;
      cks          <= '0;
    end else begin
      done_o    <= 1'b0;
      seq_inc_o <= 1'b0;
      err_o     <= 1'b0;
      case (state)
        S_IDLE: if (send_i) begin
          if (type_i == TYPE_LOGON || type_i == TYPE_HEARTBEAT || type_i == TYPE_LOGOUT) begin
            type_q    <= type_i;
            seq_q     <= seq_ascii_i;
            snd_q     <= sender_id_i;
            tgt_q     <= target_id_i;
            time_q    <= send_time_i;
            hb_q      <= hb_int_i;
            ready_o   <= 1'b0;
            cnt_first <= 1'b1;
            state     <= S_COUNT;
          end else begin
            err_o <= 1'b1;
          end
        end
        S_COUNT: begin
          if (cnt_first) begin
            seq_len   <= seq_n;
            snd_len   <= snd_n;
            tgt_len   <= tgt_n;
            time_len  <= time_n;
            hb_len    <= hb_n;
            blen_rem  <= blen_calc;
            dig_h     <= '0;
            dig_t     <= '0;
            cnt_first <= 1'b0;
          end else if (blen_rem >= 10'd100) begin
            blen_rem <= blen_rem - 10'd100;
            dig_h    <= dig_h + 4'd1;
          end else if (blen_rem >= 10'd10) begin
            blen_rem <= blen_rem - 10'd10;
            dig_t    <= dig_t + 4'd1;
          end else begin
            dig_o    <= blen_rem[3:0];
            seg      <= '0;
            r        <= 8'd10;
            emit_end <= 1'b0;
            cks      <= '0;
            state    <= S_HDR;
          end
        end
        S_HDR, S_BODY, S_TRAIL: begin
          if (data_valid_o && data_ready_i && out_cks) cks <= cks + data_o;
          if (!data_valid_o || data_ready_i) begin
            if (emit_end) begin
              data_valid_o <= 1'b0;
              done_o       <= 1'b1;
              seq_inc_o    <= 1'b1;
              state        <= S_DONE;
            end else begin
              data_o       <= cur_byte;
              data_valid_o <= 1'b1;
              out_cks      <= (seg <= 5'd16);
              if (r == 8'd1) begin
                seg      <= nxt_seg;
                r        <= nxt_len;
                emit_end <= (seg == 5'd19);
                state    <= (nxt_seg >= 5'd17) ? S_TRAIL : (nxt_seg >= 5'd4) ? S_BODY : S_HDR;
              end else begin
                r <= r - 8'd1;
              end
            end
          end
        end
        S_DONE: begin
          ready_o <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fix_msg_composer.sv
// Directed bench for fix_msg_composer: expected streams are written out by hand,
// checksum digits come from a byte-sum model over the expected text.
module tb_fix_msg_composer;

  localparam int VW = 64;
  localparam int TW = 168;

  logic          clk = 1'b0;
  logic          rst;
  logic          send_i;
  logic [3:0]    type_i;
  logic [VW-1:0] seq_ascii_i, sender_id_i, target_id_i;
  logic [TW-1:0] send_time_i;
  logic [23:0]   hb_int_i;
  logic          ready_o, data_valid_o, data_ready_i, done_o, seq_inc_o, err_o;
  logic [7:0]    data_o;

  int checks = 0;
  int failures = 0;

  fix_msg_composer #(.VALUE_WIDTH(VW), .TIME_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .send_i(send_i), .type_i(type_i),
    .seq_ascii_i(seq_ascii_i), .sender_id_i(sender_id_i), .target_id_i(target_id_i),
    .send_time_i(send_time_i), .hb_int_i(hb_int_i), .ready_o(ready_o),
    .data_o(data_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
    .done_o(done_o), .seq_inc_o(seq_inc_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sends one message, collects the stream and compares it with body + "10=ccc|".
  task automatic run_msg(input string tag, input logic [3:0] t, input bit stall,
                         input bit resend, input string body, output logic [23:0] ccc_got);
    logic [7:0] expq[$];
    logic [7:0] rxq[$];
    logic [7:0] b, held;
    string tail;
    int sum, ndone, nseq, mis, hold_err, first_valid, done_at, extra, n;
    bit prev_stall;
    sum = 0; ndone = 0; nseq = 0; mis = 0; hold_err = 0; extra = 0;
    first_valid = -1; done_at = -1; prev_stall = 0; held = '0;
    for (int i = 0; i < body.len(); i++) begin
      b = (body[i] == 8'h7C) ? 8'h01 : body[i];
      expq.push_back(b);
      sum += b;
    end
    tail = $sformatf("10=%03d|", sum % 256);
    for (int i = 0; i < tail.len(); i++) expq.push_back((tail[i] == 8'h7C) ? 8'h01 : tail[i]);

    @(negedge clk);
    check_val({tag, "_ready_idle"}, ready_o, 1);
    type_i = t;
    send_i = 1'b1;
    @(negedge clk);
    send_i = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_stall && !(data_valid_o && data_o == held)) hold_err++;
      if (first_valid < 0 && data_valid_o) first_valid = cyc;
      if (done_o) ndone++;
      if (seq_inc_o) nseq++;
      if (done_o != seq_inc_o) mis++;
      if (done_at >= 0 && data_valid_o) extra++;
      if (done_o && done_at < 0) done_at = cyc;
      if (resend && cyc == 15) begin
        send_i = 1'b1;
        type_i = 4'hA;
        sender_id_i = "CHANGED!";
      end else begin
        send_i = 1'b0;
      end
      data_ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (data_valid_o && data_ready_i) rxq.push_back(data_o);
      prev_stall = data_valid_o && !data_ready_i;
      held = data_o;
      if (done_at >= 0 && cyc > done_at + 50) break;
      @(negedge clk);
    end
    data_ready_i = 1'b1;

    check_val({tag, "_done_cnt"}, ndone, 1);
    check_val({tag, "_seqinc_cnt"}, nseq, 1);
    check_val({tag, "_done_eq_seqinc"}, mis, 0);
    check_val({tag, "_hold"}, hold_err, 0);
    check_val({tag, "_latency_le40"}, (first_valid >= 0 && first_valid <= 40), 1);
    check_val({tag, "_no_extra"}, extra, 0);
    check_val({tag, "_ready_after"}, ready_o, 1);
    check_val({tag, "_len"}, rxq.size(), expq.size());
    n = (rxq.size() < expq.size()) ? rxq.size() : expq.size();
    for (int i = 0; i < n; i++) check_val($sformatf("%s_b%0d", tag, i), rxq[i], expq[i]);
    ccc_got = (rxq.size() >= 4) ? {rxq[rxq.size()-4], rxq[rxq.size()-3], rxq[rxq.size()-2]} : 24'h0;
  endtask

  initial begin
    logic [23:0] ccc;
    int cnt, ndone, nvalid;
    rst = 1'b1; send_i = 1'b0; type_i = 4'h0; data_ready_i = 1'b1;
    seq_ascii_i = "1"; sender_id_i = "S"; target_id_i = "T";
    send_time_i = "20240101-12:00:00.000"; hb_int_i = "30";
    repeat (3) @(negedge clk);
    check_val("rst_ready", ready_o, 1);
    check_val("rst_valid", data_valid_o, 0);
    check_val("rst_data", data_o, 0);
    check_val("rst_done", done_o, 0);
    check_val("rst_seqinc", seq_inc_o, 0);
    check_val("rst_err", err_o, 0);
    rst = 1'b0;

    run_msg("hb", 4'h0, 0, 0,
      "8=FIX.4.3|9=45|35=0|34=1|49=S|52=20240101-12:00:00.000|56=T|", ccc);
    run_msg("logon", 4'hA, 0, 0,
      "8=FIX.4.3|9=57|35=A|34=1|49=S|52=20240101-12:00:00.000|56=T|98=0|108=30|", ccc);
    run_msg("hb_stall", 4'h0, 1, 0,
      "8=FIX.4.3|9=45|35=0|34=1|49=S|52=20240101-12:00:00.000|56=T|", ccc);

    seq_ascii_i = "99999999"; sender_id_i = "SENDER01"; target_id_i = "TARGET01";
    run_msg("wide", 4'h0, 0, 1,
      "8=FIX.4.3|9=66|35=0|34=99999999|49=SENDER01|52=20240101-12:00:00.000|56=TARGET01|", ccc);

    seq_ascii_i = "1"; sender_id_i = "#"; target_id_i = "3";
    run_msg("cks7", 4'h0, 0, 0,
      "8=FIX.4.3|9=45|35=0|34=1|49=#|52=20240101-12:00:00.000|56=3|", ccc);
    check_val("cks7_digits", ccc, 24'h303037);
    sender_id_i = "S"; target_id_i = "T";

    @(negedge clk);
    type_i = 4'hF; send_i = 1'b1;
    @(negedge clk);
    send_i = 1'b0;
    check_val("bad_err_pulse", err_o, 1);
    check_val("bad_ready", ready_o, 1);
    check_val("bad_valid", data_valid_o, 0);
    @(negedge clk);
    check_val("bad_err_clear", err_o, 0);
    nvalid = 0;
    repeat (40) begin
      if (data_valid_o || !ready_o) nvalid++;
      @(negedge clk);
    end
    check_val("bad_quiet", nvalid, 0);

    type_i = 4'h0; send_i = 1'b1;
    @(negedge clk);
    send_i = 1'b0;
    cnt = 0;
    for (int cyc = 0; cyc < 300 && cnt < 20; cyc++) begin
      if (data_valid_o && data_ready_i) cnt++;
      if (cnt < 20) @(negedge clk);
    end
    check_val("mid_reached_body", cnt, 20);
    rst = 1'b1;
    @(negedge clk);
    check_val("mid_rst_valid", data_valid_o, 0);
    check_val("mid_rst_ready", ready_o, 1);
    check_val("mid_rst_done", done_o, 0);
    check_val("mid_rst_seqinc", seq_inc_o, 0);
    rst = 1'b0;
    ndone = 0; nvalid = 0;
    repeat (60) begin
      @(negedge clk);
      if (done_o || seq_inc_o) ndone++;
      if (data_valid_o) nvalid++;
    end
    check_val("mid_no_done", ndone, 0);
    check_val("mid_no_output", nvalid, 0);

    run_msg("logout", 4'h5, 0, 0,
      "8=FIX.4.3|9=45|35=5|34=1|49=S|52=20240101-12:00:00.000|56=T|", ccc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fix_msg_composer.md
Name: fix_msg_composer

Overview:
- Transmit-side counterpart of the received-message path: builds outbound FIX 4.3 session-level messages (Logon, Heartbeat, Logout) on request from the session manager.
- Serialises each message as an ASCII byte stream with valid/ready handshake toward the TCP/transport layer.
- Computes BodyLength(9) and CheckSum(10) in hardware, and tells the sequence generator to advance after each completed message.

Parameters:
- VALUE_WIDTH, `VALUE_DATA_WIDTH: width of the ASCII comp-ID and seq-num fields. Must be a multiple of 8. Leading 0x00 bytes are padding.
- TIME_WIDTH, 168: SendingTime field width, 21 ASCII chars "YYYYMMDD-HH:MM:SS.sss".

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- send_i  in  1  request pulse; accepted only when ready_o=1
- type_i  in  4  message type code from defines.vh: `logon, `heartbeat, `logout
- seq_ascii_i  in  VALUE_WIDTH  MsgSeqNum(34) in ASCII, from sequence generator
- sender_id_i  in  VALUE_WIDTH  SenderCompID(49) in ASCII
- target_id_i  in  VALUE_WIDTH  TargetCompID(56) in ASCII
- send_time_i  in  TIME_WIDTH  SendingTime(52) in ASCII
- hb_int_i  in  24  HeartBtInt(108) in ASCII; leading 0x00 bytes skipped
- ready_o  out  1  idle and able to accept send_i
- data_o  out  8  output byte
- data_valid_o  out  1  data_o is valid
- data_ready_i  in  1  downstream accepts the byte
- done_o  out  1  one-cycle pulse after the final SOH is accepted
- seq_inc_o  out  1  one-cycle pulse, coincident with done_o, to the sequence generator
- err_o  out  1  one-cycle pulse when an unsupported type_i is requested

Behaviour:
- Reset values: ready_o=1; data_o=0; data_valid_o=0; done_o=0; seq_inc_o=0; err_o=0; state=IDLE.
- Message layout (SOH=0x01): "8=FIX.4.3" SOH "9=" len SOH "35=" t SOH "34=" seq SOH "49=" snd SOH "52=" time SOH "56=" tgt SOH, then for Logon only "98=0" SOH "108=" hb SOH, then "10=" ccc SOH.
- MsgType characters: `logon='A', `heartbeat='0', `logout='5'.
- ASCII fields are emitted MSB byte first. Leading 0x00 bytes are skipped. An all-zero field emits an empty value; the tag and SOH are still emitted.
- BodyLength: byte count from the '3' of "35=" through the SOH before "10=".
  - Emitted in decimal with no leading zeros. Valid range 1..999.
  - Binary-to-decimal conversion is sequential (compare/subtract allowed).
- CheckSum: sum mod 256 of every byte from '8' through the SOH before "10=". Emitted as exactly 3 decimal digits with leading zeros.
- On accepting send_i (ready_o=1 and send_i=1), all inputs are latched. Later input changes do not affect the message in flight.
- States:
  - IDLE: wait for send_i. An unsupported type_i pulses err_o the next cycle, produces no output, and the FSM stays in IDLE.
  - COUNT: dry-run walk of the body to compute BodyLength. No output. Takes at most one cycle per body byte plus conversion.
  - HDR: emit "8=FIX.4.3" SOH "9=" len SOH.
  - BODY: emit body fields.
  - TRAIL: emit "10=" ccc SOH.
  - DONE: one cycle; pulse done_o and seq_inc_o; return to IDLE with ready_o=1.
- ready_o=0 in every state except IDLE.
- Handshake:
  - A byte transfers when data_valid_o=1 and data_ready_i=1.
  - While data_ready_i=0, data_o and data_valid_o hold.
  - Throughput is one byte per cycle under continuous ready.
  - First data_valid_o rises no more than 40 cycles after send_i is accepted.
- The checksum accumulates only on transferred bytes. A stall does not double-count.
- send_i while busy is ignored; it is neither queued nor flagged.
- rst mid-message: output is abandoned immediately and every output returns to its reset value on the next edge. No done_o or seq_inc_o is issued.

Test Plan:
- Heartbeat with sender "S", target "T", seq "1", time "20240101-12:00:00.000":
  - Stream must be "8=FIX.4.3|9=45|35=0|34=1|49=S|52=20240101-12:00:00.000|56=T|10=ccc|".
  - ccc must equal the reference-model mod-256 sum in 3 digits.
  - done_o and seq_inc_o pulse exactly once.
- Logon with the same fields and hb_int_i="30":
  - BodyLength 57; "98=0|108=30|" appears before "10=".
- Backpressure: same Heartbeat with data_ready_i toggled randomly at 50% duty.
  - Byte sequence and checksum are identical to the unstalled run.
  - data_o holds stable on every stalled cycle.
- Boundary and ignore cases:
  - seq_ascii_i="99999999", 8-char comp IDs: BodyLength has 2 digits with no leading zero.
  - A message whose byte sum mod 256 is 7 gives checksum "007".
  - A second send_i during emission is ignored.
- Unsupported type_i=4'hF: err_o pulses one cycle; data_valid_o stays 0; ready_o stays 1.
- rst asserted mid-BODY: next cycle data_valid_o=0 and ready_o=1, with no done_o or seq_inc_o.
  - A following Logout then emits correctly from "8=".
